// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit.
//   state_e    : controller states (IDLE waits for start, RUN walks the chunks)
//   DEF_WIDTH  : default operand/result width
//   DEF_DIGIT  : default bits processed per clock
//   cnt_width  : width of a counter able to index n chunks (minimum 1 bit)
package seq_chunk_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DIGIT = 4;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: purely combinational DIGIT-bit ripple-carry adder.
//   x, y      : DIGIT-bit addends
//   ci        : carry into bit 0
//   s         : DIGIT-bit sum
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (xor with co gives signed overflow)
module chunk_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    s        = '0;
    c        = ci;
    c_msb_in = ci;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb_in = c;
      end
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/subtract, DIGIT bits per clock,
// least-significant chunk first, carry held in a register between chunks.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request, accepted only while ready=1
//   a, b       : operands, sampled on the accept edge
//   cin        : carry-in (add) / borrow-in (sub), sampled on the accept edge
//   sub        : 0 -> a+b+cin, 1 -> a-b-cin (computed as a + ~b + !cin)
//   ready      : high while idle
//   done       : one-cycle pulse when sum/cout/ovf update
//   sum        : result modulo 2^WIDTH, held until the next completion
//   cout       : carry out of the MSB chunk (1 = no borrow in sub mode)
//   ovf        : signed overflow
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / DIGIT;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] cs;
  logic             cco;
  logic             cmsb;
  logic [WIDTH-1:0] s_ext;

  chunk_adder #(
    .DIGIT (DIGIT)
  ) u_chunk (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .s        (cs),
    .co       (cco),
    .c_msb_in (cmsb)
  );

  // Operands shift right one chunk per cycle and results shift in at the
  // top of the accumulator, so the adder always sees bits [DIGIT-1:0] and no
  // chunk-index multiplexers are needed; after NCHUNK shifts acc is aligned.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    s_ext   = '0;
    s_ext[DIGIT-1:0] = cs;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = (acc_q >> DIGIT) | (s_ext << (WIDTH - DIGIT));
        carry_d = cco;
        idx_d   = idx_q + CW'(1);
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = cco;
          ovf_d   = cco ^ cmsb;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed testbench for seq_chunk_adder at WIDTH=16, DIGIT=4.
module tb_seq_chunk_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        ready;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int unsigned n_vec;
  int unsigned n_err;
  logic [15:0] prev_sum;

  seq_chunk_adder #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and check latency, hold behaviour and result.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vcin, input logic vsub, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    int unsigned lat;
    bit          got;
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
    tick();
    start = 1'b0;
    // operands may change freely once accepted
    a = 16'($urandom); b = 16'($urandom); cin = ~vcin; sub = ~vsub;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (done) begin
        got = 1'b1;
        break;
      end
      chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(prev_sum));
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, lat, 32'd4);
      chk({tag, "_sum"}, 32'(sum), 32'(esum));
      chk({tag, "_cout"}, 32'(cout), 32'(ecout));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
      prev_sum = esum;
    end
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_sum_after"}, 32'(sum), 32'(esum));
  endtask

  initial begin
    int unsigned dcount;
    n_vec = 0;
    n_err = 0;
    prev_sum = 16'h0000;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready), 32'd1);

    run_op("ripple",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_brw",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run_op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Handshake: a start during RUN is ignored.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();                                   // E0 accept
    start = 1'b0;
    tick();                                   // E1
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();                                   // E2, ignored
    start = 1'b0;
    dcount = 0;
    tick();                                   // E3
    if (done) dcount++;
    tick();                                   // E4
    chk("hs_done", 32'(done), 32'd1);
    chk("hs_sum", 32'(sum), 32'h0002);
    if (done) dcount++;
    // Back-to-back start in the done cycle.
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    tick();                                   // E5 accept
    start = 1'b0;
    chk("b2b_ready", 32'(ready), 32'd0);
    chk("b2b_done_low", 32'(done), 32'd0);
    if (done) dcount++;
    chk("hs_one_pulse", dcount, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_wait", 32'(done), 32'd0);
      chk("b2b_hold", 32'(sum), 32'h0002);
    end
    tick();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_sum", 32'(sum), 32'h2345);
    prev_sum = 16'h2345;
    tick();

    // Reset mid-RUN after two chunks.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_sum", 32'(sum), 32'h0);
    chk("mrst_ready", 32'(ready), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) dcount++;
    end
    chk("mrst_no_done", dcount, 32'd0);
    prev_sum = 16'h0000;
    run_op("after_rst", 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
